alu_arb2: RTL

ALU_ARB2 -- requirements
Module: alu_arb2

---
 rtl/alu_arb2.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arb2.sv
// -----------------------------------------------------------------------------
// alu_arb2
// Two-requester front end for a single shared ALU. One operation is in flight
// at a time: an idle-state round-robin arbiter accepts a request, the captured
// operands are issued to the ALU for one cycle, the result (or an error for an
// illegal opcode / missing result) is held as a response until it is consumed.
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_reqK_valid / o_reqK_ready    request handshake for requester K (0/1)
//   i_reqK_a, i_reqK_b             signed Q6.5 operands
//   i_reqK_inst                    opcode: 000 add, 001 sub, 010 mul, 011 mac
//   o_alu_valid/_a/_b/_inst        one-cycle issue to the shared ALU
//   i_alu_valid/_data/_overflow    ALU result
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_id/_data/_overflow/_err  response payload (err: illegal op/timeout)
//   o_busy                         high whenever not idle
// -----------------------------------------------------------------------------
module alu_arb2 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  input  logic        i_req1_valid,
  output logic        o_req0_ready,
  output logic        o_req1_ready,
  input  logic [11:0] i_req0_a,
  input  logic [11:0] i_req0_b,
  input  logic [11:0] i_req1_a,
  input  logic [11:0] i_req1_b,
  input  logic [2:0]  i_req0_inst,
  input  logic [2:0]  i_req1_inst,
  output logic        o_alu_valid,
  output logic [11:0] o_alu_a,
  output logic [11:0] o_alu_b,
  output logic [2:0]  o_alu_inst,
  input  logic        i_alu_valid,
  input  logic [11:0] i_alu_data,
  input  logic        i_alu_overflow,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [11:0] o_rsp_data,
  output logic        o_rsp_overflow,
  output logic        o_rsp_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Last WAIT count at which a result is still accepted.
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [11:0] op_a_q, op_a_d;
  logic [11:0] op_b_q, op_b_d;
  logic [2:0]  op_inst_q, op_inst_d;
  logic        op_id_q, op_id_d;
  logic        rsp_id_q, rsp_id_d;
  logic [11:0] rsp_data_q, rsp_data_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant_valid_s;
  logic        grant_id_s;
  logic [11:0] sel_a_s;
  logic [11:0] sel_b_s;
  logic [2:0]  sel_inst_s;
  logic        ready0_s;
  logic        ready1_s;

  // Round-robin pick: a tie goes to the requester that was not granted last.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    logic g;
    if (v0 && v1) begin
      g = ~last;
    end else if (v1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

  // Illegal opcode decode: codes 3'b100 through 3'b111.
  function automatic logic is_illegal(input logic [2:0] inst);
    return inst[2];
  endfunction

  assign grant_valid_s = i_req0_valid | i_req1_valid;
  assign grant_id_s    = pick_grant(i_req0_valid, i_req1_valid, last_grant_q);
  assign sel_a_s       = grant_id_s ? i_req1_a    : i_req0_a;
  assign sel_b_s       = grant_id_s ? i_req1_b    : i_req0_b;
  assign sel_inst_s    = grant_id_s ? i_req1_inst : i_req0_inst;

  // Next-state, capture and ready decode for the one-op-in-flight FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_inst_d    = op_inst_q;
    op_id_d      = op_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    ready0_s     = 1'b0;
    ready1_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          ready0_s     = ~grant_id_s;
          ready1_s     = grant_id_s;
          last_grant_d = grant_id_s;
          op_a_d       = sel_a_s;
          op_b_d       = sel_b_s;
          op_inst_d    = sel_inst_s;
          op_id_d      = grant_id_s;
          if (is_illegal(sel_inst_s)) begin
            // Answered immediately; the ALU never sees it.
            state_d    = ST_RESP;
            rsp_id_d   = grant_id_s;
            rsp_data_d = 12'h000;
            rsp_ovf_d  = 1'b0;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = 4'd0;
      end
      ST_WAIT: begin
        // A result in the final counted cycle still beats the timeout.
        if (i_alu_valid) begin
          state_d    = ST_RESP;
          rsp_id_d   = op_id_q;
          rsp_data_d = i_alu_data;
          rsp_ovf_d  = i_alu_overflow;
          rsp_err_d  = 1'b0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_RESP;
          rsp_id_d   = op_id_q;
          rsp_data_d = 12'h000;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves requester 0 the first tie winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= 4'd0;
      op_a_q       <= 12'h000;
      op_b_q       <= 12'h000;
      op_inst_q    <= 3'd0;
      op_id_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 12'h000;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_inst_q    <= op_inst_d;
      op_id_q      <= op_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Ready has to answer valid in the same cycle, so it is decoded, and it is
  // forced low while reset is held so no output is ever high during reset.
  assign o_req0_ready   = ready0_s & i_rst_n;
  assign o_req1_ready   = ready1_s & i_rst_n;

  assign o_alu_valid    = (state_q == ST_ISSUE);
  assign o_alu_a        = op_a_q;
  assign o_alu_b        = op_b_q;
  assign o_alu_inst     = op_inst_q;

  assign o_rsp_valid    = (state_q == ST_RESP);
  assign o_rsp_id       = rsp_id_q;
  assign o_rsp_data     = rsp_data_q;
  assign o_rsp_overflow = rsp_ovf_q;
  assign o_rsp_err      = rsp_err_q;

  assign o_busy         = (state_q != ST_IDLE);

endmodule
